// File: rtl/vc_stream_demux4.sv
// vc_stream_demux4: four-way valid/ready stream demultiplexer.
//
// Each message on the input stream goes to the output port named by its select field.
// Every output has its own 2-entry FIFO. A stalled consumer only blocks messages that are
// headed for that consumer.
//
// Build option:
//   VC_STREAM_DEMUX_BYPASS_EN -- if this macro is defined, an empty FIFO whose consumer is
//   ready passes the incoming message straight through in the same cycle (0-cycle latency).
//   If it is undefined, every output is registered and the latency is exactly one cycle.
//
// Ports:
//   clk_i                  clock, rising edge
//   reset_ni               asynchronous active-low reset
//   in_val_i / in_rdy_o    input handshake; in_rdy_o depends only on state and in_sel_i
//   in_sel_i [1:0]         destination port of the message on in_msg_i
//   in_msg_i [W-1:0]       input message
//   outK_val_o / outK_rdy_i / outK_msg_o  output port K (K = 0..3)

module vc_stream_demux4 #(
   parameter int unsigned W = 1
) (
   input  logic         clk_i,
   input  logic         reset_ni,

   input  logic         in_val_i,
   output logic         in_rdy_o,
   input  logic [1:0]   in_sel_i,
   input  logic [W-1:0] in_msg_i,

   output logic         out0_val_o,
   input  logic         out0_rdy_i,
   output logic [W-1:0] out0_msg_o,

   output logic         out1_val_o,
   input  logic         out1_rdy_i,
   output logic [W-1:0] out1_msg_o,

   output logic         out2_val_o,
   input  logic         out2_rdy_i,
   output logic [W-1:0] out2_msg_o,

   output logic         out3_val_o,
   input  logic         out3_rdy_i,
   output logic [W-1:0] out3_msg_o
);

   logic [3:0]   out_rdy;
   logic [3:0]   out_val;
   logic [W-1:0] out_msg [4];
   logic [3:0]   full;

   assign out_rdy = {out3_rdy_i, out2_rdy_i, out1_rdy_i, out0_rdy_i};

   // Acceptance is decided only by the occupancy of the selected FIFO. It never looks at
   // the consumer's ready, so there is no combinational path from outK_rdy to in_rdy.
   assign in_rdy_o = !full[in_sel_i];

   for (genvar k = 0; k < 4; k++) begin : g_fifo
      logic [W-1:0] mem_q [2];
      logic         head_q, head_d;
      logic         tail_q, tail_d;
      logic [1:0]   cnt_q, cnt_d;
      logic         sel_hit;
      logic         byp;
      logic         enq;
      logic         deq;

      assign sel_hit = (in_sel_i == 2'(k));

`ifdef VC_STREAM_DEMUX_BYPASS_EN
      // Empty FIFO with a ready consumer: the message goes straight through and is not
      // stored.
      assign byp = (cnt_q == 2'd0) && in_val_i && sel_hit && out_rdy[k];
`else
      assign byp = 1'b0;
`endif

      assign full[k] = (cnt_q == 2'd2);
      assign enq     = in_val_i && sel_hit && !full[k] && !byp;
      assign deq     = (cnt_q != 2'd0) && out_rdy[k];

      assign out_val[k] = (cnt_q != 2'd0) || byp;
      assign out_msg[k] = byp ? in_msg_i : mem_q[head_q];

      always_comb begin
         head_d = head_q ^ deq;
         tail_d = tail_q ^ enq;
         cnt_d  = cnt_q;
         unique case ({enq, deq})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;  // idle, or enqueue and dequeue in the same cycle
         endcase
      end

      always_ff @(posedge clk_i or negedge reset_ni) begin
         if (!reset_ni) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
            cnt_q  <= 2'd0;
         end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
         end
      end

      // Message storage has no reset. Only pointers and counts are cleared.
      always_ff @(posedge clk_i) begin
         if (enq) begin
            mem_q[tail_q] <= in_msg_i;
         end
      end
   end

   assign out0_val_o = out_val[0];
   assign out1_val_o = out_val[1];
   assign out2_val_o = out_val[2];
   assign out3_val_o = out_val[3];

   assign out0_msg_o = out_msg[0];
   assign out1_msg_o = out_msg[1];
   assign out2_msg_o = out_msg[2];
   assign out3_msg_o = out_msg[3];

endmodule

// File: doc/vc_stream_demux4.md
# vc_stream_demux4

Four-way val/rdy stream demultiplexer: routes each message arriving on one input stream to one of four output streams, chosen by a per-message select field. Each output has its own 2-entry FIFO, so a stalled consumer blocks only messages destined for it. It fans one producer out to four consumers, for example a response network splitting replies back to four requesters.

## Interface
- W, default 1: message width in bits.
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_val  input  1  input message valid.
- in_rdy  output  1  input can accept.
- in_sel  input  2  destination port (0..3) of the message on in_msg.
- in_msg  input  W  input message.
- out0_val / out1_val / out2_val / out3_val  output  1 each  output port valid.
- out0_rdy / out1_rdy / out2_rdy / out3_rdy  input  1 each  output port ready.
- out0_msg / out1_msg / out2_msg / out3_msg  output  W each  output port message.

## Operation
- Per output k: 2-entry FIFO with head pointer (1 bit), tail pointer (1 bit) and count (2 bits, values 0..2).
- Data storage is not reset; pointers and counts are.
- in_rdy = (count[in_sel] != 2), which depends only on registered state and in_sel.
- in_rdy is never combinationally dependent on any outK_rdy.
- Input transfer: in_val && in_rdy → in_msg is written at tail[in_sel]; tail and count of that FIFO update at the edge.
- outK_val = (countK != 0); outK_msg = entry at headK.
- Output transfer: outK_val && outK_rdy → headK advances and countK decrements.
- Same-cycle enqueue and dequeue on one FIFO: count is unchanged and both pointers advance.
- Enqueue into a full FIFO cannot occur, because in_rdy is low.
- Pointers wrap 1→0 (modulo 2).
- Ordering is preserved within each output. There is no ordering guarantee across outputs.
- in_sel and in_msg are ignored when in_val is low.
- Each output is independent: a full FIFO k deasserts in_rdy only while in_sel == k.
- in_rdy is a function of in_sel. Producers must hold in_sel stable while in_val is high.

## Timing
- Reset (reset_n low, asynchronous): all counts = 0 and pointers = 0 immediately.
- Reset values of outputs: out*_val = 0; in_rdy = 1.
- out*_msg is undefined (X) until the first write.
- Reset asserted mid-operation discards all buffered messages. No output transfer occurs in that cycle.
- Reset deassertion is synchronized externally. The block requires no idle cycles after release.
- Latency: a message accepted at edge t is visible on outK at t+1 (1 cycle).
- Throughput: 1 message/cycle into any output whose consumer drains every cycle.
- Throughput: 2 back-to-back messages absorbed per stalled output before backpressure.

## Configuration
- VC_STREAM_DEMUX_BYPASS_EN defined:
  - When FIFO k is empty and in_val && in_sel == k && outK_rdy, in_msg is driven combinationally onto outK_msg with outK_val = 1 in the same cycle.
  - The bypassed message is not enqueued, and in_rdy is 1. Latency is 0.
  - In this configuration outK_val/outK_msg depend combinationally on in_val/in_sel/in_msg.
  - in_rdy still never depends on outK_rdy.
- Undefined: no bypass; latency is always exactly 1 cycle and all outputs are registered.

## Test plan
- Reset checks → out*_val = 0 and in_rdy = 1.
  - Reset, all out_rdy = 1.
  - Assert reset_n low mid-cycle with 2 entries queued on out2 → out2_val drops immediately, with no clock edge.
- Basic routing, W = 8, all out_rdy = 1 → each message appears once on its port, one cycle later; other ports stay invalid.
  - Send 0xA0 sel 0, 0xA1 sel 1, 0xA2 sel 2, 0xA3 sel 3 on consecutive cycles.
- Backpressure:
  - Hold out1_rdy = 0 and send 0x11, 0x12, 0x13 to sel 1 → in_rdy low on the third attempt.
  - Release out1_rdy → 0x11 then 0x12 delivered in order, then 0x13 is accepted.
- Isolation: out1 full and stalled; send 0x30 sel 3 → in_rdy = 1, accepted, 0x30 delivered on out3.
- Simultaneous enqueue/dequeue: out0 holds 1 entry and out0_rdy = 1; send 0x55 sel 0 each cycle for 20 cycles → count stays 1, pointers wrap, FIFO order preserved.
- Random stress: 1000 messages with random sel, in_val and outK_rdy checked against a 4-queue scoreboard → no loss, duplication or reordering per port.
  - With BYPASS_EN: an empty port with rdy high shows 0-cycle latency.
